bcd_entry_display: RTL and testbench
====================================

BCD_ENTRY_DISPLAY -- requirements
Module: bcd_entry_display

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a press or a release.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clock cycles each display digit stays active.
REQ-003 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port key_code  input  4  BCD digit from the upstream priority encoder.
REQ-006 SHALL have port key_valid  input  1  high while any of the ten encoder inputs is asserted.
REQ-007 SHALL have port clear  input  1  synchronous clear of the entry buffer.
REQ-008 SHALL have port digits  output  16  four-digit entry buffer; digits[3:0] holds the newest digit.
REQ-009 SHALL have port entry_count  output  3  number of valid digits, 0..4.
REQ-010 SHALL have port new_digit  output  1  one-cycle pulse when a digit is shifted in.
REQ-011 SHALL have port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 SHALL have port an  output  4  active-low digit enables; an[0] is the rightmost digit.

Function
REQ-013 Debounce FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus one stability counter.
REQ-014 IDLE: key_valid=1 SHALL go to PRESS_WAIT with counter=1; otherwise stay.
REQ-015 PRESS_WAIT: key_valid=0 SHALL go to IDLE with counter=0; when counter reaches DEBOUNCE_CYCLES with key_valid=1, it SHALL accept the press and go to HELD.
REQ-016 HELD: key_valid=0 SHALL go to RELEASE_WAIT with counter=1; a held key SHALL never auto-repeat.
REQ-017 RELEASE_WAIT: key_valid=1 SHALL return to HELD; DEBOUNCE_CYCLES stable low cycles SHALL go to IDLE.
REQ-018 On acceptance, key_code SHALL be sampled that cycle; on the next edge digits={digits[11:0],key_code}, entry_count=min(entry_count+1,4) and new_digit=1 for exactly one cycle.
REQ-019 After 4 entries, the oldest digit SHALL be discarded on each further accept, with entry_count held at 4.
REQ-020 key_code>9 at acceptance SHALL be rejected: no shift, no pulse, and the FSM still goes to HELD.
REQ-021 clear=1 SHALL set digits=0 and entry_count=0 on the next edge and SHALL win over a simultaneous accept (that digit is dropped, no pulse); clear SHALL NOT alter the FSM.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1, then wrap and rotate an as 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-023 seg SHALL be the decode of the digit at the active position i (digits[4i+3:4i]); positions with i >= entry_count SHALL show blank 1111111.
REQ-024 Decode (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 seg and an SHALL be registered and change together, one cycle after the scan wrap.

Reset
REQ-026 rst_n=0 SHALL immediately force FSM=IDLE, counters=0, digits=0, entry_count=0, new_digit=0, an=1110, seg=1111111.
REQ-027 Reset asserted mid-debounce SHALL discard the pending press, and no pulse SHALL follow deassertion.

Structure
REQ-028 A shared package/header bcd_entry_pkg SHALL hold the FSM state encodings, the segment constants SEG_BLANK and SEG_0..SEG_9, and the AN_INIT value.
REQ-029 The segment decode SHALL be one combinational sub-module, seg7_decoder (4-bit BCD in, blank flag in, 7-bit seg out); all other logic SHALL live in bcd_entry_display.

Verification
REQ-030 Press: key_code=5 with key_valid held 16 cycles -> new_digit pulses once, digits=0x0005, entry_count=1.
REQ-031 Bounce: key_valid high for 10 cycles, low for 1, high for 16 -> exactly one pulse, and only after the final 16-cycle run.
REQ-032 Overflow: enter 1,2,3,4,5 with clean releases -> digits=0x2345, entry_count=4, 5 pulses.
REQ-033 Clear and accept in the same cycle, plus a rejected code: clear coincident with acceptance -> digits=0, count=0, no pulse; key_code=0xA pressed -> no pulse, no shift.
REQ-034 Display (SCAN_DIV=4): digits=0x0037, count=2 -> an=1110 with seg=1111000, then an=1101 with seg=0110000, then an=1011 and an=0111 both with seg=1111111.
REQ-035 Reset mid-PRESS_WAIT (counter=10), then release reset with key still held -> IDLE, outputs at reset values, pulse only after 16 new stable cycles.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the BCD keypad entry / display block: debounce
// FSM encoding, active-low seven-segment patterns and the digit-enable
// value the scan starts from.
package bcd_entry_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Rightmost digit enabled first (active-low).
    localparam logic [3:0] AN_INIT = 4'b1110;

    // Number of digits the entry buffer keeps.
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    // True for a code that is a legal decimal digit.
    function automatic logic is_bcd(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder with a blank
// override. Codes above 9 also decode to blank.
module seg7_decoder
    import bcd_entry_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Pattern lookup; blank wins over any code.
    // NOTE: seg_o is given a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_entry_display.sv
// Keypad digit entry with debounce, a four-digit shift-in buffer and a
// multiplexed four-digit seven-segment display. A press is accepted after
// DEBOUNCE_CYCLES consecutive high samples of key_valid and a release after
// the same number of low samples; a held key never repeats.
module bcd_entry_display
    import bcd_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SCAN_DIV        = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [2:0]  entry_count,
    output logic        new_digit,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    deb_state_e        state_q;
    logic [CNT_W-1:0]  deb_cnt_q;
    logic              press_accept;

    logic [15:0]       digits_q, digits_d;
    logic [2:0]        count_q, count_d;
    logic              new_digit_q, new_digit_d;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        pos_q;
    logic              scan_wrap;
    logic [3:0]        act_bcd;
    logic              act_blank;
    logic [6:0]        seg_dec;
    logic [6:0]        seg_q;
    logic [3:0]        an_q;

    // The press is accepted in the cycle the stable-high run reaches its
    // target, so key_code is taken from that same cycle.
    assign press_accept = (state_q == PRESS_WAIT) && key_valid && (deb_cnt_q >= DEB_LAST);

    // Debounce FSM: counts consecutive stable samples in the two wait states.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        state_q   <= PRESS_WAIT;
                        deb_cnt_q <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_valid) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else if (press_accept) begin
                        state_q   <= HELD;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!key_valid) begin
                        state_q   <= RELEASE_WAIT;
                        deb_cnt_q <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_valid) begin
                        state_q   <= HELD;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q >= DEB_LAST) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    deb_cnt_q <= '0;
                end
            endcase
        end
    end

    // Entry buffer next state: clear beats an accept; codes above 9 are
    // dropped without disturbing the buffer.
    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        new_digit_d = 1'b0;
        if (clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (press_accept && is_bcd(key_code)) begin
            digits_d    = {digits_q[11:0], key_code};
            count_d     = (count_q >= MAX_DIGITS) ? MAX_DIGITS : count_q + 3'd1;
            new_digit_d = 1'b1;
        end
    end

    // Entry buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q    <= '0;
            count_q     <= '0;
            new_digit_q <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            new_digit_q <= new_digit_d;
        end
    end

    assign scan_wrap = (scan_cnt_q == SCAN_LAST);

    // Scan timer: advance the active position once per SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            pos_q      <= '0;
        end else begin
            if (scan_wrap) begin
                scan_cnt_q <= '0;
                pos_q      <= pos_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
        end
    end

    // Active digit select; positions beyond the entry count stay dark.
    assign act_bcd   = digits_q[{pos_q, 2'b00} +: 4];
    assign act_blank = ({1'b0, pos_q} >= count_q);

    seg7_decoder u_seg7_decoder (
        .bcd_i   (act_bcd),
        .blank_i (act_blank),
        .seg_o   (seg_dec)
    );

    // Display outputs registered together so segments and enable switch on
    // the same edge, one cycle after the position advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_INIT;
        end else begin
            seg_q <= seg_dec;
            an_q  <= ~(4'b0001 << pos_q);
        end
    end

    assign digits      = digits_q;
    assign entry_count = count_q;
    assign new_digit   = new_digit_q;
    assign seg         = seg_q;
    assign an          = an_q;

endmodule

// File: tb/tb_bcd_entry_display.sv
// Self-checking bench for bcd_entry_display: directed scenarios plus a
// randomized run against a run-length reference model of the keypad entry
// and a cycle-count model of the display scan.
module tb_bcd_entry_display;

    localparam int DEB  = 16;
    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic [2:0]  entry_count;
    logic        new_digit;
    logic [6:0]  seg;
    logic [3:0]  an;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_entry_display #(
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_DIV        (SCAN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .clear       (clear),
        .digits      (digits),
        .entry_count (entry_count),
        .new_digit   (new_digit),
        .seg         (seg),
        .an          (an)
    );

    // ---------------- reference model ----------------
    bit          latched;   // a press has been taken and not yet released
    int          run;       // consecutive samples opposing the current phase
    logic [15:0] m_digits;
    int          m_count;
    logic        m_pulse;
    int          edges;     // clock edges since reset released
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latched  = 1'b0;
            run      = 0;
            m_digits = 16'h0;
            m_count  = 0;
            m_pulse  = 1'b0;
            edges    = 0;
            m_an     = 4'b1110;
            m_seg    = 7'b1111111;
        end else begin
            int  p;
            bit  acc;
            p     = (edges / SCAN) % 4;
            m_an  = 4'b1111;
            m_an[p] = 1'b0;
            m_seg = (p < m_count) ? ref_seg(m_digits[4*p +: 4]) : 7'b1111111;
            edges++;
            acc = 1'b0;
            if (!latched) begin
                if (key_valid) begin
                    run++;
                    if (run == DEB) begin acc = 1'b1; latched = 1'b1; run = 0; end
                end else run = 0;
            end else begin
                if (!key_valid) begin
                    run++;
                    if (run == DEB) begin latched = 1'b0; run = 0; end
                end else run = 0;
            end
            m_pulse = 1'b0;
            if (clear) begin
                m_digits = 16'h0;
                m_count  = 0;
            end else if (acc && key_code <= 4'd9) begin
                m_digits = {m_digits[11:0], key_code};
                m_count  = (m_count < 4) ? m_count + 1 : 4;
                m_pulse  = 1'b1;
            end
        end
    end

    // Drive one cycle of inputs from a falling edge, return at the next one.
    task automatic step(input logic kv, input logic [3:0] code, input logic clr);
        key_valid = kv;
        key_code  = code;
        clear     = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (digits !== 16'h0) begin miscompares++; $display("FAIL reset_digits got %h want 0000", digits); end
        vectors++; if (entry_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", entry_count); end
        vectors++; if (new_digit !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got %b want 0", new_digit); end
        vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL reset_an got %b want 1110", an); end
        vectors++; if (seg !== 7'b1111111) begin miscompares++; $display("FAIL reset_seg got %b want 1111111", seg); end
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_press();
        int pulses = 0;
        for (int i = 0; i < DEB; i++) begin
            step(1'b1, 4'd5, 1'b0);
            if (new_digit) pulses++;
            vectors++;
            if (new_digit !== (i == DEB - 1)) begin
                miscompares++; $display("FAIL press_pulse cyc %0d got %b want %b", i, new_digit, (i == DEB - 1));
            end
        end
        for (int i = 0; i < DEB + 2; i++) begin
            step(1'b0, 4'd5, 1'b0);
            if (new_digit) pulses++;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL press_count_pulses got %0d want 1", pulses); end
        vectors++; if (digits !== 16'h0005) begin miscompares++; $display("FAIL press_digits got %h want 0005", digits); end
        vectors++; if (entry_count !== 3'd1) begin miscompares++; $display("FAIL press_count got %0d want 1", entry_count); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 27; i++) begin
            step((i != 10), 4'd8, 1'b0);
            if (new_digit) pulses++;
            vectors++;
            if (new_digit !== (i == 26)) begin
                miscompares++; $display("FAIL bounce_pulse cyc %0d got %b want %b", i, new_digit, (i == 26));
            end
        end
        for (int i = 0; i < DEB + 2; i++) begin
            step(1'b0, 4'd8, 1'b0);
            if (new_digit) pulses++;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
        vectors++; if (digits !== 16'h0058) begin miscompares++; $display("FAIL bounce_digits got %h want 0058", digits); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        step(1'b0, 4'd0, 1'b1);
        for (int d = 1; d <= 5; d++) begin
            for (int i = 0; i < DEB; i++) begin
                step(1'b1, 4'(d), 1'b0);
                if (new_digit) pulses++;
            end
            for (int i = 0; i < DEB + 2; i++) begin
                step(1'b0, 4'(d), 1'b0);
                if (new_digit) pulses++;
            end
        end
        vectors++; if (pulses != 5) begin miscompares++; $display("FAIL overflow_pulses got %0d want 5", pulses); end
        vectors++; if (digits !== 16'h2345) begin miscompares++; $display("FAIL overflow_digits got %h want 2345", digits); end
        vectors++; if (entry_count !== 3'd4) begin miscompares++; $display("FAIL overflow_count got %0d want 4", entry_count); end
    endtask

    task automatic test_clear_reject();
        int pulses = 0;
        // Clear lands on the accepting cycle.
        for (int i = 0; i < DEB; i++) begin
            step(1'b1, 4'd6, (i == DEB - 1));
            if (new_digit) pulses++;
        end
        vectors++; if (digits !== 16'h0) begin miscompares++; $display("FAIL clracc_digits got %h want 0000", digits); end
        vectors++; if (entry_count !== 3'd0) begin miscompares++; $display("FAIL clracc_count got %0d want 0", entry_count); end
        for (int i = 0; i < DEB + 2; i++) begin
            step(1'b0, 4'd6, 1'b0);
            if (new_digit) pulses++;
        end
        // Non-decimal code.
        for (int i = 0; i < DEB + 4; i++) begin
            step(1'b1, 4'hA, 1'b0);
            if (new_digit) pulses++;
        end
        for (int i = 0; i < DEB + 2; i++) begin
            step(1'b0, 4'hA, 1'b0);
            if (new_digit) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL reject_pulses got %0d want 0", pulses); end
        vectors++; if (digits !== 16'h0) begin miscompares++; $display("FAIL reject_digits got %h want 0000", digits); end
        // Long hold: one digit only.
        for (int i = 0; i < 3 * DEB; i++) begin
            step(1'b1, 4'd9, 1'b0);
            if (new_digit) pulses++;
        end
        for (int i = 0; i < DEB + 2; i++) begin
            step(1'b0, 4'd9, 1'b0);
            if (new_digit) pulses++;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL hold_pulses got %0d want 1", pulses); end
        vectors++; if (digits !== 16'h0009) begin miscompares++; $display("FAIL hold_digits got %h want 0009", digits); end
    endtask

    task automatic test_display();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        int guard;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b1111000, 7'b0110000, 7'b1111111, 7'b1111111};
        step(1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEB; i++) step(1'b1, (k == 0) ? 4'd3 : 4'd7, 1'b0);
            for (int i = 0; i < DEB + 2; i++) step(1'b0, 4'd0, 1'b0);
        end
        vectors++; if (digits !== 16'h0037 || entry_count !== 3'd2) begin
            miscompares++; $display("FAIL disp_setup got %h/%0d want 0037/2", digits, entry_count);
        end
        guard = 0;
        while (an === 4'b1110 && guard < 40) begin step(1'b0, 4'd0, 1'b0); guard++; end
        while (an !== 4'b1110 && guard < 40) begin step(1'b0, 4'd0, 1'b0); guard++; end
        vectors++;
        if (guard >= 40) begin
            miscompares++; $display("FAIL disp_sync an never returned to 1110, got %b", an);
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < SCAN; j++) begin
                    vectors++;
                    if (an !== exp_an[k] || seg !== exp_seg[k]) begin
                        miscompares++;
                        $display("FAIL disp_pos%0d cyc %0d got an=%b seg=%b want an=%b seg=%b", k, j, an, seg, exp_an[k], exp_seg[k]);
                    end
                    step(1'b0, 4'd0, 1'b0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 4'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++; if (digits !== 16'h0 || entry_count !== 3'd0 || new_digit !== 1'b0 || an !== 4'b1110 || seg !== 7'b1111111) begin
            miscompares++; $display("FAIL midrst_outputs got %h/%0d/%b/%b/%b want 0000/0/0/1110/1111111", digits, entry_count, new_digit, an, seg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            step(1'b1, 4'd4, 1'b0);
            if (new_digit) pulses++;
            vectors++;
            if (new_digit !== (i == DEB - 1)) begin
                miscompares++; $display("FAIL midrst_pulse cyc %0d got %b want %b", i, new_digit, (i == DEB - 1));
            end
        end
        for (int i = 0; i < DEB + 2; i++) step(1'b0, 4'd4, 1'b0);
        vectors++; if (pulses != 1 || digits !== 16'h0004 || entry_count !== 3'd1) begin
            miscompares++; $display("FAIL midrst_entry got %0d pulses %h/%0d want 1 pulse 0004/1", pulses, digits, entry_count);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        for (int r = 0; r < 60; r++) begin
            logic       kv;
            logic [3:0] code;
            int         len;
            kv   = r[0];
            len  = (($urandom % 4) == 0) ? $urandom_range(1, 6) : $urandom_range(12, 24);
            code = (($urandom % 6) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            for (int i = 0; i < len; i++) begin
                step(kv, code, (($urandom % 50) == 0));
                cyc++;
                vectors++;
                if (digits !== m_digits || entry_count !== 3'(m_count) || new_digit !== m_pulse ||
                    an !== m_an || seg !== m_seg) begin
                    miscompares++;
                    $display("FAIL random cyc %0d got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b", cyc,
                             digits, entry_count, new_digit, an, seg, m_digits, m_count, m_pulse, m_an, m_seg);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_press();
        test_bounce();
        test_overflow();
        test_clear_reject();
        test_display();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
